// File: rtl/fifo_reader_if.sv
// fifo_reader_if: upstream FIFO read port, downstream valid/ready output, flush and status.
interface fifo_reader_if #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 fifo_empty;
    logic [WORD_SIZE-1:0] fifo_data;
    logic                 fifo_rd_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic                 flush;
    logic [CNT_WIDTH-1:0] pop_count;
    logic                 busy;
    modport master (
        input  fifo_empty, fifo_data, out_ready, flush,
        output fifo_rd_en, out_valid, out_data, pop_count, busy
    );
    modport slave (
        output fifo_empty, fifo_data, out_ready, flush,
        input  fifo_rd_en, out_valid, out_data, pop_count, busy
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: pops a 1-cycle-latency upstream FIFO into a 2-entry in-order valid/ready output buffer.
module fifo_reader #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    fifo_reader_if.master   bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
    occ_e                 occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [WORD_SIZE-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rd_en, capture, handshake;
    // Occupancy plus the in-flight read may never exceed two words.
    assign rd_en     = !rst && !bus.flush && !bus.fifo_empty &&
                       ((occ_q == EMPTY) || (occ_q == ONE && !inflight_q));
    assign capture   = inflight_q && !bus.flush;
    assign handshake = (occ_q != EMPTY) && bus.out_ready;
    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = rd_en;
        cnt_d      = cnt_q + CNT_WIDTH'(handshake && !bus.flush);
        case (occ_q)
            EMPTY: begin
                head_d = capture ? bus.fifo_data : head_q;
                occ_d  = capture ? ONE : EMPTY;
            end
            ONE: begin
                head_d = (capture && handshake) ? bus.fifo_data : head_q;
                tail_d = (capture && !handshake) ? bus.fifo_data : tail_q;
                occ_d  = (capture == handshake) ? ONE : (capture ? TWO : EMPTY);
            end
            TWO: begin
                head_d = handshake ? tail_q : head_q;
                tail_d = (capture && handshake) ? bus.fifo_data : tail_q;
                occ_d  = (handshake && !capture) ? ONE : TWO;
            end
            default: occ_d = EMPTY;
        endcase
        if (bus.flush) begin
            occ_d      = EMPTY;
            inflight_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end
    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = occ_q != EMPTY;
    assign bus.out_data   = head_q;
    assign bus.pop_count  = cnt_q;
    assign bus.busy       = (occ_q != EMPTY) || inflight_q;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed stimulus with an upstream FIFO model and a scoreboard monitor on output handshakes.
module tb_fifo_reader;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rd_pulses = 0;
    int   base;
    logic [31:0] up_q[$];
    logic [31:0] exp_q[$];
    fifo_reader_if #(.WORD_SIZE(32), .CNT_WIDTH(4)) bus ();
    fifo_reader #(.WORD_SIZE(32), .CNT_WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Upstream FIFO: data appears the cycle after an accepted pop.
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            rd_pulses++;
            if (up_q.size() != 0) bus.fifo_data <= up_q.pop_front();
        end
    end
    always @(negedge clk) bus.fifo_empty <= (up_q.size() == 0);
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask
    task automatic push(input logic [31:0] w, input bit expect_out);
        up_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (up_q.size() == 0 && !bus.busy && !bus.fifo_rd_en) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL drain_timeout: busy=%0b upstream=%0d", bus.busy, up_q.size());
    endtask
    // Scoreboard monitor: every counted handshake must present the next expected word.
    always @(negedge clk) begin
        if (!rst && !bus.flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h, expected none", bus.out_data);
            end else begin
                chk("stream_word", bus.out_data, exp_q.pop_front());
            end
        end
    end
    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        step();
        push(32'h11, 1); push(32'h22, 1); push(32'h33, 1);
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_count", 32'(bus.pop_count), 0);
        chk("rst_data", bus.out_data, 0);
        step();
        rst = 1'b0;
        drain();
        chk("stream_count", 32'(bus.pop_count), 3);
        bus.out_ready = 1'b0;
        step();
        base = rd_pulses;
        push(32'h44, 1); push(32'h55, 1); push(32'h66, 1); push(32'h77, 1);
        repeat (8) @(negedge clk);
        chk("bp_pulses", 32'(rd_pulses - base), 2);
        chk("bp_valid", 32'(bus.out_valid), 1);
        chk("bp_data", bus.out_data, 32'h44);
        chk("bp_busy", 32'(bus.busy), 1);
        repeat (3) @(negedge clk);
        chk("bp_hold", bus.out_data, 32'h44);
        step();
        bus.out_ready = 1'b1;
        drain();
        chk("bp_count", 32'(bus.pop_count), 7);
        step();
        push(32'h88, 1); push(32'h99, 1);
        repeat (3) @(negedge clk);
        chk("sim_head0", bus.out_data, 32'h88);
        @(negedge clk);
        chk("sim_valid", 32'(bus.out_valid), 1);
        chk("sim_head1", bus.out_data, 32'h99);
        drain();
        chk("sim_count", 32'(bus.pop_count), 9);
        bus.out_ready = 1'b0;
        step();
        base = rd_pulses;
        push(32'hA1, 0); push(32'hA2, 0); push(32'hA3, 1);
        repeat (4) @(negedge clk);
        chk("fl2_full_pulses", 32'(rd_pulses - base), 2);
        chk("fl2_head", bus.out_data, 32'hA1);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fl2_valid", 32'(bus.out_valid), 0);
        chk("fl2_busy", 32'(bus.busy), 0);
        chk("fl2_count", 32'(bus.pop_count), 9);
        bus.out_ready = 1'b1;
        drain();
        chk("fl2_after", 32'(bus.pop_count), 10);
        step();
        push(32'hB1, 0); push(32'hB2, 0); push(32'hB3, 1);
        @(posedge clk);
        step();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl1_inflight", 32'(bus.busy && bus.out_valid), 1);
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fl1_valid", 32'(bus.out_valid), 0);
        chk("fl1_busy", 32'(bus.busy), 0);
        chk("fl1_count", 32'(bus.pop_count), 10);
        drain();
        chk("fl1_after", 32'(bus.pop_count), 11);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("wrap_reset", 32'(bus.pop_count), 0);
        step();
        for (int i = 0; i < 17; i++) push(32'h100 + 32'(i), 1);
        drain();
        chk("wrap_count", 32'(bus.pop_count), 1);
        bus.out_ready = 1'b0;
        step();
        push(32'hC1, 0); push(32'hC2, 0); push(32'hC3, 1);
        repeat (4) @(negedge clk);
        chk("mid_full", bus.out_data, 32'hC1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_valid", 32'(bus.out_valid), 0);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_data", bus.out_data, 0);
        chk("mid_count", 32'(bus.pop_count), 0);
        bus.out_ready = 1'b1;
        drain();
        chk("mid_after", 32'(bus.pop_count), 1);
        chk("scoreboard_left", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
